rv32i_datapath: RTL and testbench

RV32I datapath core for the multi-cycle CPU: instruction decode, ALU/branch/jump execution with a private data memory, and register write-back selection. The CPU top drives the fetch/decode/execute/write sequencing, owns the PC and the register file, and feeds this block the current instruction and operands. The block returns register indices, the next PC and the write-back request.

---
 rtl/rv_defs_pkg.sv | 74 +++++++
 rtl/rv32i_datapath_decoder.sv | 60 ++++++
 rtl/rv32i_datapath_executer.sv | 126 ++++++++++++
 rtl/rv32i_datapath_writer.sv | 15 +
 rtl/rv32i_datapath.sv | 58 +++++
 tb/tb_rv32i_datapath.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/rv_defs_pkg.sv
// Shared RV32I encodings, ALU operation set and the decoded control bundle
// passed from the decoder to the execute and write-back stages.
package rv_defs_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // instruction bit 30 selects SUB/SRA over ADD/SRL
  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC, ALU_LINK
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        use_imm;
    logic [2:0]  br_cond;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        reg_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
  } control_info;

  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_datapath_decoder.sv
// Combinational RV32I decoder: register indices, sign-extended immediate
// and control flags for one instruction.
module rv32i_datapath_decoder
  import rv_defs_pkg::*;
(
  input  logic [31:0] instr_i,
  output control_info ctrl_o
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  f3;

  assign f3    = instr_i[14:12];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.rd  = instr_i[11:7];
    ctrl_o.rs1 = instr_i[19:15];
    ctrl_o.rs2 = instr_i[24:20];
    case (instr_i[6:0])
      OPC_LUI:   begin ctrl_o.reg_write = 1'b1; ctrl_o.imm = imm_u; ctrl_o.alu_op = ALU_LUI; end
      OPC_AUIPC: begin ctrl_o.reg_write = 1'b1; ctrl_o.imm = imm_u; ctrl_o.alu_op = ALU_AUIPC; end
      OPC_JAL:   begin ctrl_o.reg_write = 1'b1; ctrl_o.is_jal = 1'b1; ctrl_o.imm = imm_j; ctrl_o.alu_op = ALU_LINK; end
      OPC_JALR:  begin ctrl_o.reg_write = 1'b1; ctrl_o.is_jalr = 1'b1; ctrl_o.imm = imm_i; ctrl_o.alu_op = ALU_LINK; end
      OPC_BRANCH: begin ctrl_o.is_branch = 1'b1; ctrl_o.imm = imm_b; ctrl_o.br_cond = f3; end
      OPC_LOAD: begin
        ctrl_o.reg_write    = 1'b1;
        ctrl_o.is_load      = 1'b1;
        ctrl_o.imm          = imm_i;
        ctrl_o.use_imm      = 1'b1;
        ctrl_o.mem_size     = f3[1:0];
        ctrl_o.mem_unsigned = f3[2];
      end
      OPC_STORE: begin
        ctrl_o.is_store = 1'b1;
        ctrl_o.imm      = imm_s;
        ctrl_o.use_imm  = 1'b1;
        ctrl_o.mem_size = f3[1:0];
      end
      // bit 30 of an I-immediate only means SRAI for the right-shift funct3
      OPC_OPIMM: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm       = imm_i;
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.alu_op    = alu_from_funct(f3, (f3 == F3_SR) && (instr_i[31:25] == F7_ALT));
      end
      OPC_OP: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = alu_from_funct(f3, instr_i[31:25] == F7_ALT);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_datapath_executer.sv
// ALU, branch resolution, byte-lane data memory and the execute-result
// registers that hold values for the write cycle.
module rv32i_datapath_executer
  import rv_defs_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  control_info ctrl_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] rs2_val_i,
  input  logic        exec_en_i,
  output logic [31:0] jump_dest_o,
  output logic [31:0] exec_rd_o,
  output logic [31:0] memory_out_o
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem_q [DMEM_WORDS];
  logic [31:0]   exec_rd_q, exec_rd_d, rdata_q;
  logic [1:0]    lane_q;
  logic [31:0]   op_b, pc_plus4, addr, store_data;
  logic [4:0]    shamt;
  logic [3:0]    byte_en;
  logic [AW-1:0] word_idx;
  logic          cond, taken;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_exec;

  assign op_b     = ctrl_i.use_imm ? ctrl_i.imm : rs2_val_i;
  assign shamt    = op_b[4:0];
  assign pc_plus4 = pc_i + 32'd4;
  assign addr     = rs1_val_i + ctrl_i.imm;
  assign word_idx = addr[AW+1:2];

  always_comb begin
    exec_rd_d = '0;
    case (ctrl_i.alu_op)
      ALU_ADD:   exec_rd_d = rs1_val_i + op_b;
      ALU_SUB:   exec_rd_d = rs1_val_i - op_b;
      ALU_SLL:   exec_rd_d = rs1_val_i << shamt;
      ALU_SLT:   exec_rd_d = {31'b0, $signed(rs1_val_i) < $signed(op_b)};
      ALU_SLTU:  exec_rd_d = {31'b0, rs1_val_i < op_b};
      ALU_XOR:   exec_rd_d = rs1_val_i ^ op_b;
      ALU_SRL:   exec_rd_d = rs1_val_i >> shamt;
      ALU_SRA:   exec_rd_d = $unsigned($signed(rs1_val_i) >>> shamt);
      ALU_OR:    exec_rd_d = rs1_val_i | op_b;
      ALU_AND:   exec_rd_d = rs1_val_i & op_b;
      ALU_LUI:   exec_rd_d = ctrl_i.imm;
      ALU_AUIPC: exec_rd_d = pc_i + ctrl_i.imm;
      ALU_LINK:  exec_rd_d = pc_plus4;
      default:   exec_rd_d = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (ctrl_i.br_cond)
      F3_BEQ:  cond = rs1_val_i == rs2_val_i;
      F3_BNE:  cond = rs1_val_i != rs2_val_i;
      F3_BLT:  cond = $signed(rs1_val_i) < $signed(rs2_val_i);
      F3_BGE:  cond = $signed(rs1_val_i) >= $signed(rs2_val_i);
      F3_BLTU: cond = rs1_val_i < rs2_val_i;
      F3_BGEU: cond = rs1_val_i >= rs2_val_i;
      default: cond = 1'b0;
    endcase
    taken = ctrl_i.is_branch && cond;
  end

  always_comb begin
    jump_dest_o = pc_plus4;
    if (ctrl_i.is_jal || taken) jump_dest_o = pc_i + ctrl_i.imm;
    else if (ctrl_i.is_jalr)    jump_dest_o = addr & ~32'd1;
  end

  // narrow stores replicate their data so every enabled lane sees the right byte
  always_comb begin
    byte_en    = 4'b1111;
    store_data = rs2_val_i;
    case (ctrl_i.mem_size)
      MEM_B: begin byte_en = 4'b0001 << addr[1:0]; store_data = {4{rs2_val_i[7:0]}}; end
      MEM_H: begin byte_en = addr[1] ? 4'b1100 : 4'b0011; store_data = {2{rs2_val_i[15:0]}}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (exec_en_i && !rst_i && ctrl_i.is_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exec_rd_q <= '0;
      rdata_q   <= '0;
      lane_q    <= '0;
    end else if (exec_en_i) begin
      exec_rd_q <= exec_rd_d;
      rdata_q   <= mem_q[word_idx];
      lane_q    <= addr[1:0];
    end
  end

  // lane extraction after the read register; the instruction is still held
  always_comb begin
    byte_sel     = rdata_q[{lane_q, 3'b000} +: 8];
    half_sel     = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    memory_out_o = rdata_q;
    case (ctrl_i.mem_size)
      MEM_B:   memory_out_o = ctrl_i.mem_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_H:   memory_out_o = ctrl_i.mem_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  assign exec_rd_o   = exec_rd_q;
  assign unused_exec = ^{ctrl_i.rd, ctrl_i.rs1, ctrl_i.rs2, ctrl_i.reg_write, ctrl_i.is_load, addr};

endmodule

// File: rtl/rv32i_datapath_writer.sv
// Write-back selection: register-file write request and its value.
module rv32i_datapath_writer (
  input  logic        reg_write_i,
  input  logic        is_load_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] exec_rd_i,
  input  logic [31:0] memory_out_i,
  output logic        write_enable_o,
  output logic [31:0] write_data_o
);

  assign write_enable_o = reg_write_i && (rd_i != 5'd0);
  assign write_data_o   = is_load_i ? memory_out_i : exec_rd_i;

endmodule

// File: rtl/rv32i_datapath.sv
// RV32I datapath wrapper: wires decoder, executer and writer together for
// the host's fetch/decode/execute/write sequence.
module rv32i_datapath
  import rv_defs_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTRUCTION,
  input  logic [31:0] PC,
  output logic [4:0]  RS1,
  output logic [4:0]  RS2,
  input  logic [31:0] RS1_VAL,
  input  logic [31:0] RS2_VAL,
  input  logic        EXEC_EN,
  output logic [31:0] JUMP_DEST,
  output logic [4:0]  RD,
  output logic        WRITE_ENABLE,
  output logic [31:0] WRITE_DATA
);

  control_info ctrl;
  logic [31:0] exec_rd, memory_out;

  rv32i_datapath_decoder u_decoder (
    .instr_i (INSTRUCTION),
    .ctrl_o  (ctrl)
  );

  rv32i_datapath_executer #(.DMEM_WORDS(DMEM_WORDS)) u_executer (
    .clk_i        (CLK),
    .rst_i        (RST),
    .ctrl_i       (ctrl),
    .pc_i         (PC),
    .rs1_val_i    (RS1_VAL),
    .rs2_val_i    (RS2_VAL),
    .exec_en_i    (EXEC_EN),
    .jump_dest_o  (JUMP_DEST),
    .exec_rd_o    (exec_rd),
    .memory_out_o (memory_out)
  );

  rv32i_datapath_writer u_writer (
    .reg_write_i    (ctrl.reg_write),
    .is_load_i      (ctrl.is_load),
    .rd_i           (ctrl.rd),
    .exec_rd_i      (exec_rd),
    .memory_out_i   (memory_out),
    .write_enable_o (WRITE_ENABLE),
    .write_data_o   (WRITE_DATA)
  );

  assign RS1 = ctrl.rs1;
  assign RS2 = ctrl.rs2;
  assign RD  = ctrl.rd;

endmodule

// File: tb/tb_rv32i_datapath.sv
// Scoreboard bench: each issued instruction pushes its expected response;
// a monitor compares decode, execute and write-cycle outputs as they appear.
module tb_rv32i_datapath;

  localparam int DMEM_WORDS = 256;
  localparam int MEM_BYTES  = 4 * DMEM_WORDS;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] INSTRUCTION = '0;
  logic [31:0] PC = '0;
  logic [31:0] RS1_VAL = '0;
  logic [31:0] RS2_VAL = '0;
  logic        EXEC_EN = 1'b0;
  logic [4:0]  RS1, RS2, RD;
  logic [31:0] JUMP_DEST, WRITE_DATA;
  logic        WRITE_ENABLE;

  rv32i_datapath #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .PC(PC),
    .RS1(RS1), .RS2(RS2), .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL),
    .EXEC_EN(EXEC_EN), .JUMP_DEST(JUMP_DEST), .RD(RD),
    .WRITE_ENABLE(WRITE_ENABLE), .WRITE_DATA(WRITE_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] jd;
    logic        we;
    logic [31:0] wd;
    logic        chk_wd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  int         phase = 0;   // 0 idle, 1 decode, 2 execute, 3 write
  logic [7:0] mem_b [MEM_BYTES];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // ---------------- reference model (ISA-level) ----------------
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y, input logic alt);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mem_b[a & (MEM_BYTES - 1)];
  endfunction

  function automatic exp_t model(input string name, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b, input logic rst);
    exp_t e;
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] imm_u = {ins[31:12], 12'b0};
    logic [31:0] imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    logic [31:0] res = '0, ea, base;
    logic        wr = 1'b0, tk;
    e.name = name; e.instr = ins;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.jd = pc + 4;
    case (ins[6:0])
      7'b0110111: begin wr = 1; res = imm_u; end
      7'b0010111: begin wr = 1; res = pc + imm_u; end
      7'b1101111: begin wr = 1; res = pc + 4; e.jd = pc + imm_j; end
      7'b1100111: begin wr = 1; res = pc + 4; e.jd = (a + imm_i) & ~32'd1; end
      7'b1100011: begin
        case (f3)
          3'd0: tk = a == b;
          3'd1: tk = a != b;
          3'd4: tk = $signed(a) < $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a < b;
          3'd7: tk = a >= b;
          default: tk = 0;
        endcase
        if (tk) e.jd = pc + imm_b;
      end
      7'b0000011: begin
        wr = 1; ea = a + imm_i;
        case (f3)
          3'd0: res = {{24{rdb(ea)[7]}}, rdb(ea)};
          3'd4: res = {24'b0, rdb(ea)};
          3'd1, 3'd5: begin
            base = ea & ~32'd1;
            res = {16'b0, rdb(base + 1), rdb(base)};
            if (f3 == 3'd1 && res[15]) res = res | 32'hFFFF0000;
          end
          default: begin
            base = ea & ~32'd3;
            res = {rdb(base + 3), rdb(base + 2), rdb(base + 1), rdb(base)};
          end
        endcase
      end
      7'b0100011: begin
        ea = a + imm_s;
        if (!rst) begin
          case (f3)
            3'd0: mem_b[ea & (MEM_BYTES - 1)] = b[7:0];
            3'd1: for (int k = 0; k < 2; k++) mem_b[((ea & ~32'd1) + k) & (MEM_BYTES - 1)] = b[8*k +: 8];
            default: for (int k = 0; k < 4; k++) mem_b[((ea & ~32'd3) + k) & (MEM_BYTES - 1)] = b[8*k +: 8];
          endcase
        end
      end
      7'b0010011: begin wr = 1; res = alu(f3, a, imm_i, (f3 == 3'd5) && ins[30]); end
      7'b0110011: begin wr = 1; res = alu(f3, a, b, ins[30]); end
      default: ;
    endcase
    e.we = wr && (ins[11:7] != 5'd0);
    e.wd = rst ? 32'd0 : res;
    e.chk_wd = wr || rst;
    return e;
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // ---------------- stimulus ----------------
  task automatic run(input string name, input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] b, input logic rst, input logic use_x, input logic [31:0] x_jd,
                     input logic x_we, input logic [31:0] x_wd, input logic x_chk);
    exp_t e = model(name, ins, pc, a, b, rst);
    if (use_x) begin e.jd = x_jd; e.we = x_we; e.wd = x_wd; e.chk_wd = x_chk; end
    exp_q.push_back(e);
    @(posedge CLK); #1 INSTRUCTION = ins; PC = pc; phase = 1;
    @(posedge CLK); #1 RS1_VAL = a; RS2_VAL = b; EXEC_EN = 1'b1; RST = rst; phase = 2;
    @(posedge CLK); #1 EXEC_EN = 1'b0; RST = 1'b0; RS1_VAL = $urandom; RS2_VAL = $urandom; phase = 3;
    @(posedge CLK); #1 phase = 0;
  endtask

  task automatic rnd_one();
    int          cls = $urandom_range(0, 9);
    logic [4:0]  rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
    logic [2:0]  f3 = 3'($urandom);
    logic [31:0] pc = {20'b0, 10'($urandom), 2'b00};
    logic [31:0] a = $urandom, b = $urandom, r = $urandom, ins;
    logic [11:0] im = 12'($urandom);
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic        rst = ($urandom_range(0, 24) == 0);
    case (cls)
      0: ins = {r[31:12], rd, 7'b0110111};
      1: ins = {r[31:12], rd, 7'b0010111};
      2: ins = enc_j({r[20:1], 1'b0}, rd);
      3: ins = enc_i(im, rs1, 3'd0, rd, 7'b1100111);
      4: begin
        ins = enc_b({r[12:1], 1'b0}, rs2, rs1, br_f3[$urandom_range(0, 5)]);
        if ($urandom_range(0, 2) == 0) b = a;
      end
      5: begin a = $urandom_range(0, 255); ins = enc_i(12'($urandom_range(0, 63)), rs1, ld_f3[$urandom_range(0, 4)], rd, 7'b0000011); end
      6: begin a = $urandom_range(0, 255); ins = enc_s(12'($urandom_range(0, 63)), rs2, rs1, 3'($urandom_range(0, 2))); end
      7: begin
        if (f3 == 3'd1) im[11:5] = 7'h00;
        if (f3 == 3'd5) im[11:5] = r[0] ? 7'h20 : 7'h00;
        ins = enc_i(im, rs1, f3, rd, 7'b0010011);
      end
      8: ins = {((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'b0110011};
      default: ins = {r[31:7], r[0] ? 7'b0001111 : 7'b1110011};
    endcase
    run("rand", ins, pc, a, b, rst, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (phase != 0) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
      end else begin
        mon_e = exp_q[0];
        case (phase)
          1: begin
            check32({mon_e.name, ".rs1"}, {27'b0, RS1}, {27'b0, mon_e.rs1});
            check32({mon_e.name, ".rs2"}, {27'b0, RS2}, {27'b0, mon_e.rs2});
            check32({mon_e.name, ".rd"}, {27'b0, RD}, {27'b0, mon_e.rd});
          end
          2: check32({mon_e.name, ".jump_dest"}, JUMP_DEST, mon_e.jd);
          default: begin
            check32({mon_e.name, ".write_enable"}, {31'b0, WRITE_ENABLE}, {31'b0, mon_e.we});
            if (mon_e.chk_wd) check32({mon_e.name, ".write_data"}, WRITE_DATA, mon_e.wd);
            $display("txn %-10s instr=%08h we=%0d wd=%08h jd=%08h", mon_e.name, mon_e.instr, WRITE_ENABLE, WRITE_DATA, mon_e.jd);
            void'(exp_q.pop_front());
          end
        endcase
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'h00;
    INSTRUCTION = 32'h00100093;   // addi x1,x0,1
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check32("reset.write_data", WRITE_DATA, 32'd0);
    check32("reset.write_enable", {31'b0, WRITE_ENABLE}, 32'd1);

    // establish known memory contents
    for (int i = 0; i < DMEM_WORDS; i++)
      run("clear", enc_s(12'd0, 5'd0, 5'd1, 3'd2), 32'h200, 32'(i * 4), 32'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    run("addi",   32'hFE010113, 32'h100, 32'd500, 32'd0, 0, 1, 32'h104, 1, 32'd468, 1);
    run("jal",    32'h034000EF, 32'h0,   32'd0,   32'd0, 0, 1, 32'h34,  1, 32'd4,   1);
    run("ret",    32'h00008067, 32'h34,  32'h4C,  32'd0, 0, 1, 32'h4C,  0, 32'd0,   0);
    run("sw",     32'hFEA42623, 32'h10,  32'd468, 32'd5, 0, 1, 32'h14,  0, 32'd0,   0);
    run("lw",     32'hFEC42783, 32'h14,  32'd468, 32'd0, 0, 1, 32'h18,  1, 32'd5,   1);
    run("add",    32'h00F707B3, 32'h18,  32'd4,   32'd5, 0, 1, 32'h1C,  1, 32'd9,   1);
    run("beq_t",  enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h40, 32'd7, 32'd7, 0, 1, 32'h38, 0, 32'd0, 0);
    run("beq_nt", enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h40, 32'd7, 32'd8, 0, 1, 32'h44, 0, 32'd0, 0);
    run("sb",     enc_s(12'd1, 5'd2, 5'd1, 3'd0), 32'h50, 32'h100, 32'hABCDEF80, 0, 1, 32'h54, 0, 32'd0, 0);
    run("lb",     enc_i(12'd1, 5'd1, 3'd0, 5'd3, 7'b0000011), 32'h54, 32'h100, 32'd0, 0, 1, 32'h58, 1, 32'hFFFFFF80, 1);
    run("lbu",    enc_i(12'd1, 5'd1, 3'd4, 5'd3, 7'b0000011), 32'h58, 32'h100, 32'd0, 0, 1, 32'h5C, 1, 32'h00000080, 1);
    run("lw_lane", enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'b0000011), 32'h5C, 32'h100, 32'd0, 0, 1, 32'h60, 1, 32'h00008000, 1);
    run("sh",     enc_s(12'd2, 5'd2, 5'd1, 3'd1), 32'h60, 32'h200, 32'h12348001, 0, 1, 32'h64, 0, 32'd0, 0);
    run("lh",     enc_i(12'd2, 5'd1, 3'd1, 5'd4, 7'b0000011), 32'h64, 32'h200, 32'd0, 0, 1, 32'h68, 1, 32'hFFFF8001, 1);
    run("lhu",    enc_i(12'd2, 5'd1, 3'd5, 5'd4, 7'b0000011), 32'h68, 32'h200, 32'd0, 0, 1, 32'h6C, 1, 32'h00008001, 1);
    run("sw_wrap", enc_s(12'd0, 5'd2, 5'd1, 3'd2), 32'h6C, 32'h410, 32'hCAFEBABE, 0, 1, 32'h70, 0, 32'd0, 0);
    run("lw_wrap", enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011), 32'h70, 32'h10, 32'd0, 0, 1, 32'h74, 1, 32'hCAFEBABE, 1);
    run("addi_x0", enc_i(12'd9, 5'd1, 3'd0, 5'd0, 7'b0010011), 32'h74, 32'd1, 32'd0, 0, 1, 32'h78, 0, 32'd0, 0);
    run("sw_rst", 32'hFEA42623, 32'h78,  32'd468, 32'h1234, 1, 1, 32'h7C, 0, 32'd0, 1);
    run("lw_rst", 32'hFEC42783, 32'h7C,  32'd468, 32'd0,    0, 1, 32'h80, 1, 32'd5, 1);

    for (int i = 0; i < 400; i++) rnd_one();

    @(posedge CLK);
    @(negedge CLK);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
